button_seq_fsm: RTL
===================

BUTTON_SEQ_FSM -- requirements
Module: button_seq_fsm

Parameters
REQ-001 The block SHALL have parameter NB, default 3: number of button inputs, legal range 2..8.
REQ-002 The block SHALL have parameter ARM_MASK, default 3'b011 (NB bits): buttons that arm the sequence.
REQ-003 The block SHALL have parameter CONF_MASK, default 3'b010 (NB bits): buttons that confirm in CHECK.
REQ-004 The block SHALL have parameter EARLY_IDX, default 2: index of the button that drives early output, range 0..NB-1.
REQ-005 The block SHALL have parameter SETTLE, default 2: cycles spent in SETTLE, legal range 1..255.
REQ-006 The block SHALL have parameter LOCKOUT, default 4: cycles spent in LOCK, legal range 1..255.

Interface
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 b  input  NB  button levels, active-high, sampled each rising edge.
REQ-010 en  input  1  arming enable; only gates the IDLE->SETTLE transition.
REQ-011 abort  input  1  synchronous abort to IDLE.
REQ-012 outp  output  1  sequence output (Mealy: from state and current b).
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 hit_cnt  output  8  count of successful confirms, saturating.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, CHECK, LOCK, with an 8-bit down-counter cnt.
REQ-016 In IDLE with en=1 and (b & ARM_MASK)!=0, the FSM SHALL go to SETTLE and load cnt=SETTLE-1; otherwise it SHALL stay in IDLE.
REQ-017 In SETTLE, if cnt!=0 it SHALL decrement cnt and stay; if cnt==0 it SHALL go to CHECK; b is ignored for transitions.
REQ-018 In CHECK, if (b & CONF_MASK)!=0 it SHALL go to LOCK, load cnt=LOCKOUT-1 and increment hit_cnt; otherwise it SHALL go to IDLE.
REQ-019 hit_cnt SHALL saturate at 255 and SHALL not wrap.
REQ-020 In LOCK, if cnt!=0 it SHALL decrement and stay; if cnt==0 it SHALL go to IDLE; arming is not possible in the same edge.
REQ-021 outp SHALL be 1 throughout CHECK.
REQ-022 outp SHALL equal b[EARLY_IDX] in SETTLE only while cnt==0 (last SETTLE cycle).
REQ-023 outp SHALL be 0 in every other state and cycle.
REQ-024 abort=1 at an edge SHALL force IDLE and cnt=0, with priority over every other transition including a confirm; hit_cnt SHALL NOT increment on that edge.
REQ-025 Timing: with arm sampled at edge k, SETTLE SHALL occupy cycles k+1..k+SETTLE, CHECK cycle k+SETTLE+1, and LOCK the next LOCKOUT cycles.
REQ-026 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set state=IDLE, cnt=0 and hit_cnt=0, with priority over abort and all transitions.
REQ-028 During and after reset, busy SHALL be 0, and outp SHALL be 0.
REQ-029 Reset asserted mid-sequence (any state) SHALL take effect at the next edge with no residual outp pulse.
REQ-030 rst_n SHALL have no asynchronous effect; deasserting it between edges changes nothing until the next edge.

Verification (default parameters)
REQ-031 Arm and confirm: b=001 at edge 0, b=010 from edge 2 -> SETTLE in cycles 1-2, CHECK in cycle 3 with outp=1, LOCK in cycles 4-7, IDLE in cycle 8, hit_cnt=1.
REQ-032 Early output: b=101 held -> outp=1 in cycle 2 and cycle 3; with b=001 held -> outp=0 in cycle 2 and 1 in cycle 3; b=101 in CHECK (CONF_MASK miss) -> IDLE in cycle 4, hit_cnt unchanged.
REQ-033 Enable and mask: en=0 with b=011 -> stays IDLE, busy=0; en=1 with b=100 only -> stays IDLE.
REQ-034 Abort priority: abort=1 at the CHECK edge with b=010 -> IDLE next cycle, hit_cnt unchanged, outp=0.
REQ-035 Saturation: 260 back-to-back confirmed sequences -> hit_cnt reads 255 and holds.
REQ-036 Reset mid-LOCK: rst_n=0 for one edge in cycle 5 of a sequence -> IDLE, hit_cnt=0, busy=0 on the following cycle; arming works again immediately after.

Source files
------------

// File: rtl/button_seq_fsm.sv
// Button sequence detector: arm, settle, confirm, then lock out re-arming.
// outp is Mealy (state plus current b); hit_cnt counts confirms and saturates at 255.
module button_seq_fsm #(
  parameter int unsigned      NB        = 3,
  parameter logic [NB-1:0]    ARM_MASK  = 3'b011,
  parameter logic [NB-1:0]    CONF_MASK = 3'b010,
  parameter int unsigned      EARLY_IDX = 2,
  parameter int unsigned      SETTLE    = 2,
  parameter int unsigned      LOCKOUT   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] b,
  input  logic          en,
  input  logic          abort,
  output logic          outp,
  output logic          busy,
  output logic [7:0]    hit_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET_ST = 2'd1,
    CHECK  = 2'd2,
    LOCK   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [7:0] LOCK_LD   = 8'(LOCKOUT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       hit_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      hit_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (hit_inc && hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hit_inc  = 1'b0;
    outp     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && (b & ARM_MASK) != '0) begin
          state_nx = SET_ST;
          cnt_nx   = SETTLE_LD;
        end
      end
      SET_ST: begin
        // Early output only on the last settle cycle.
        if (cnt == 8'd0) begin
          outp     = b[EARLY_IDX];
          state_nx = CHECK;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      CHECK: begin
        outp = 1'b1;
        if ((b & CONF_MASK) != '0) begin
          state_nx = LOCK;
          cnt_nx   = LOCK_LD;
          hit_inc  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      LOCK: begin
        if (cnt == 8'd0) state_nx = IDLE;
        else             cnt_nx   = cnt - 8'd1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
    // Abort overrides everything, including a confirm in CHECK.
    if (abort) begin
      state_nx = IDLE;
      cnt_nx   = 8'd0;
      hit_inc  = 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
